// File: rtl/branch_stim_gen_pkg.sv
// Shared encodings for the branch stimulus generator and its LFSR.
// Other random testers also import this package.
package bimode_stim_pkg;

  typedef enum logic [1:0] {
    MODE_TAKEN = 2'd0,
    MODE_NOT   = 2'd1,
    MODE_LOOP  = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_PRED = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // Taps for x^16+x^14+x^13+x^11+1 in a right-shifting Fibonacci register
  localparam logic [15:0] LFSR_TAP_MASK     = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAP_MASK), s[15:1]};
  endfunction

endpackage

// File: rtl/branch_stim_gen_if.sv
// Branch/prediction handshake between the stimulus generator (master)
// and the predictor under test (slave).
interface branch_stim_gen_if #(
  parameter int ADDR_W = 64
);
  logic              br_valid;
  logic              br_ready;
  logic [ADDR_W-1:0] branch_address;
  logic              real_ton;
  logic              pred_valid;
  logic              pred_ton;

  modport master (
    output br_valid, branch_address, real_ton,
    input  br_ready, pred_valid, pred_ton
  );

  modport slave (
    input  br_valid, branch_address, real_ton,
    output br_ready, pred_valid, pred_ton
  );
endinterface

// File: rtl/branch_stim_gen_lfsr.sv
// 16-bit Fibonacci LFSR with load/step; a zero seed is replaced by the default
// so the register can never lock up.
module stim_lfsr16
  import bimode_stim_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [15:0]      i_seed,
  input  logic             i_step,
  output logic [OUT_W-1:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LFSR_DEFAULT_SEED;
    end else if (i_load) begin
      r_state <= (i_seed == 16'd0) ? LFSR_DEFAULT_SEED : i_seed;
    end else if (i_step) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state[OUT_W-1:0];

endmodule

// File: rtl/branch_stim_gen.sv
// Branch-trace generator: issues address/outcome pairs to a predictor, waits
// for each prediction, and counts issued branches and mispredictions.
module branch_stim_gen
  import bimode_stim_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter int                CNT_W     = 16,
  parameter int                NUM_SITES = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h0000_0000_0000_1000),
  parameter int                STRIDE    = 4,
  parameter int                LOOP_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [15:0]      seed,
  input  logic [CNT_W-1:0] num_branches,
  branch_stim_gen_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int SITE_W = (NUM_SITES > 1) ? $clog2(NUM_SITES) : 1;
  localparam int LOOP_W = (LOOP_LEN > 1) ? $clog2(LOOP_LEN) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e            r_state, w_next;
  mode_e             r_mode;
  logic [CNT_W-1:0]  r_remaining, r_issued, r_mispred;
  logic [SITE_W-1:0] r_site, w_site_next;
  logic [LOOP_W-1:0] r_loop_cnt, w_loop_next;
  logic              w_lfsr_bit, w_start_ok, w_hs, w_pred, w_ton;
  logic [ADDR_W-1:0] w_addr;

  assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_hs       = (r_state == ST_ISSUE) && bus.br_ready;
  assign w_pred     = (r_state == ST_WAIT_PRED) && bus.pred_valid;

  stim_lfsr16 #(.OUT_W(1)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_start_ok),
    .i_seed  (seed),
    .i_step  (w_pred),
    .o_state (w_lfsr_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: if (w_start_ok) w_next = (num_branches == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE:         if (bus.br_ready) w_next = ST_WAIT_PRED;
      ST_WAIT_PRED:     if (bus.pred_valid)
                          w_next = (r_remaining == CNT_W'(1)) ? ST_DONE : ST_ISSUE;
      default:          w_next = ST_IDLE;
    endcase
  end

  // Outcome and address are pure functions of the generator state, which only
  // moves when a prediction is consumed, so they hold through the wait.
  always_comb begin
    w_ton = 1'b0;
    unique case (r_mode)
      MODE_TAKEN: w_ton = 1'b1;
      MODE_NOT:   w_ton = 1'b0;
      MODE_LOOP:  w_ton = (r_loop_cnt != LOOP_W'(LOOP_LEN - 1));
      MODE_LFSR:  w_ton = w_lfsr_bit;
      default:    w_ton = 1'b0;
    endcase
  end

  assign w_addr      = BASE_ADDR + (ADDR_W'(r_site) * ADDR_W'(STRIDE));
  assign w_site_next = (r_site == SITE_W'(NUM_SITES - 1)) ? '0 : r_site + 1'b1;
  assign w_loop_next = (r_loop_cnt == LOOP_W'(LOOP_LEN - 1)) ? '0 : r_loop_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode      <= MODE_TAKEN;
      r_remaining <= '0;
      r_issued    <= '0;
      r_mispred   <= '0;
      r_site      <= '0;
      r_loop_cnt  <= '0;
    end else if (w_start_ok) begin
      r_mode      <= mode_e'(mode);
      r_remaining <= num_branches;
      r_issued    <= '0;
      r_mispred   <= '0;
      r_site      <= '0;
      r_loop_cnt  <= '0;
    end else if (w_hs) begin
      r_issued <= r_issued + 1'b1;
    end else if (w_pred) begin
      if (bus.pred_ton != w_ton) r_mispred <= sat_inc(r_mispred);
      r_site      <= w_site_next;
      r_loop_cnt  <= w_loop_next;
      r_remaining <= r_remaining - 1'b1;
    end
  end

  assign bus.br_valid       = (r_state == ST_ISSUE);
  assign bus.branch_address = (r_state == ST_ISSUE || r_state == ST_WAIT_PRED) ? w_addr : '0;
  assign bus.real_ton       = (r_state == ST_ISSUE || r_state == ST_WAIT_PRED) ? w_ton : 1'b0;
  assign busy               = (r_state == ST_ISSUE || r_state == ST_WAIT_PRED);
  assign done               = (r_state == ST_DONE);
  assign issued_cnt         = r_issued;
  assign mispred_cnt        = r_mispred;

endmodule

// File: tb/tb_branch_stim_gen.sv
// Randomized scoreboard bench for branch_stim_gen: a reference trace model fills
// an expectation queue that a handshake monitor drains.
module tb_branch_stim_gen;
  import bimode_stim_pkg::*;

  localparam int          ADDR_W    = 64;
  localparam int          CNT_W     = 16;
  localparam int          NUM_SITES = 4;
  localparam int          STRIDE    = 4;
  localparam int          LOOP_LEN  = 4;
  localparam logic [63:0] BASE      = 64'h1000;

  typedef struct packed {
    logic [63:0] addr;
    logic        ton;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       mode;
  logic [15:0]      seed;
  logic [CNT_W-1:0] num_br;
  logic             busy, done;
  logic [CNT_W-1:0] issued, mispred;

  logic             start4;
  logic [1:0]       mode4;
  logic [15:0]      seed4;
  logic [3:0]       num4;
  logic             busy4, done4;
  logic [3:0]       issued4, mispred4;

  branch_stim_gen_if #(.ADDR_W(ADDR_W)) bus ();
  branch_stim_gen_if #(.ADDR_W(ADDR_W)) bus4 ();

  branch_stim_gen dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .num_branches(num_br), .bus(bus), .busy(busy), .done(done),
    .issued_cnt(issued), .mispred_cnt(mispred)
  );

  branch_stim_gen #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .seed(seed4),
    .num_branches(num4), .bus(bus4), .busy(busy4), .done(done4),
    .issued_cnt(issued4), .mispred_cnt(mispred4)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  int   ready_mode = 0;
  bit   junk = 1'b0;
  int   dly_max = 0;
  int   run_id = 0;
  logic pred_tbl [0:255];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  // Ready driver: 0 = always ready, 1 = random, 2 = held low
  initial begin
    bus.br_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.br_ready = 1'b1;
        1:       bus.br_ready = 1'($urandom % 2);
        default: bus.br_ready = 1'b0;
      endcase
    end
  end

  // Predictor model: answers each accepted branch after a random delay
  initial begin
    int idx, seen, d;
    idx = 0; seen = 0;
    bus.pred_valid = 1'b0;
    bus.pred_ton   = 1'b0;
    forever begin
      @(negedge clk);
      if (seen != run_id) begin
        seen = run_id;
        idx  = 0;
      end
      if (bus.br_valid && bus.br_ready) begin
        bus.pred_valid = 1'b0;
        d = int'($urandom_range(32'(dly_max), 0));
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1;
        bus.pred_valid = 1'b1;
        bus.pred_ton   = pred_tbl[idx % 256];
        idx++;
        @(posedge clk);
        #1 bus.pred_valid = 1'b0;
      end else begin
        bus.pred_valid = junk && bus.br_valid;
        bus.pred_ton   = 1'b1;
      end
    end
  end

  // Monitor: every handshake must match the head of the expectation queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.br_valid && bus.br_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got branch at %0h, expected none", bus.branch_address);
        end else begin
          e = sb_q.pop_front();
          check("sb_addr", bus.branch_address, e.addr);
          check("sb_ton", 64'(bus.real_ton), 64'(e.ton));
        end
      end
    end
  end

  task automatic run_case(input string tag, input logic [1:0] m, input logic [15:0] sd,
                          input int n, input int pol, input int rdy, input int dly,
                          input int stall, input int abort_at);
    logic [15:0] s;
    int          exp_mis, budget;
    logic        ton, p, t0;
    logic [63:0] a, a0;
    exp_t        e;
    s = (sd == 16'd0) ? 16'hACE1 : sd;
    exp_mis = 0; a0 = '0; t0 = 1'b0;
    for (int k = 0; k < n; k++) begin
      a = BASE + 64'((k % NUM_SITES) * STRIDE);
      case (m)
        2'd0:    ton = 1'b1;
        2'd1:    ton = 1'b0;
        2'd2:    ton = ((k % LOOP_LEN) != LOOP_LEN - 1);
        default: ton = s[0];
      endcase
      p = (pol == 0) ? 1'b0 : (pol == 1) ? 1'b1 : 1'($urandom % 2);
      pred_tbl[k % 256] = p;
      if (p != ton) exp_mis++;
      e.addr = a; e.ton = ton;
      sb_q.push_back(e);
      if (k == 0) begin a0 = a; t0 = ton; end
      s = ref_step(s);
    end
    dly_max = dly;
    run_id++;
    ready_mode = (stall > 0) ? 2 : rdy;
    junk = (stall > 0);
    @(posedge clk); #1;
    start = 1'b1; mode = m; seed = sd; num_br = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0; mode = 2'($urandom); seed = 16'($urandom); num_br = CNT_W'($urandom);
    if (n == 0) begin
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_valid"}, 64'(bus.br_valid), 64'd0);
      @(negedge clk);
      check({tag, "_valid2"}, 64'(bus.br_valid), 64'd0);
      check({tag, "_issued"}, 64'(issued), 64'd0);
      return;
    end
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    check({tag, "_done_start"}, 64'(done), 64'd0);
    check({tag, "_first_valid"}, 64'(bus.br_valid), 64'd1);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        start = (i == 1);
        mode  = 2'($urandom);
        check({tag, "_stall_valid"}, 64'(bus.br_valid), 64'd1);
        check({tag, "_stall_addr"}, bus.branch_address, a0);
        check({tag, "_stall_ton"}, 64'(bus.real_ton), 64'(t0));
        check({tag, "_stall_issued"}, 64'(issued), 64'd0);
      end
      start = 1'b0;
      junk  = 1'b0;
      @(negedge clk);
      ready_mode = rdy;
    end
    budget = 40 * n + 100;
    while (budget > 0) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) break;
      budget--;
      if (abort_at > 0 && int'(issued) >= abort_at) begin
        ready_mode = 2;
        repeat (4) @(negedge clk);
        check({tag, "_pre_rst_valid"}, 64'(bus.br_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check({tag, "_rst_valid"}, 64'(bus.br_valid), 64'd0);
        check({tag, "_rst_busy"}, 64'(busy), 64'd0);
        check({tag, "_rst_done"}, 64'(done), 64'd0);
        check({tag, "_rst_issued"}, 64'(issued), 64'd0);
        check({tag, "_rst_mispred"}, 64'(mispred), 64'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ready_mode = 0;
        repeat (2) @(negedge clk);
        return;
      end
      if ($urandom % 8 == 0) begin
        start  = 1'b1;
        mode   = 2'($urandom);
        num_br = CNT_W'($urandom_range(3, 0));
      end
    end
    if (budget == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: busy still %0d, expected 0", tag, busy);
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_valid_end"}, 64'(bus.br_valid), 64'd0);
    check({tag, "_issued"}, 64'(issued), 64'(n));
    check({tag, "_mispred"}, 64'(mispred), 64'(exp_mis));
    check({tag, "_sb_left"}, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  initial begin
    int budget;
    rst = 1'b1;
    start = 1'b0; mode = '0; seed = '0; num_br = '0;
    start4 = 1'b0; mode4 = '0; seed4 = '0; num4 = '0;
    bus4.br_ready = 1'b1; bus4.pred_valid = 1'b1; bus4.pred_ton = 1'b0;
    #1;
    check("rst_valid", 64'(bus.br_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_addr", bus.branch_address, 64'd0);
    check("rst_issued", 64'(issued), 64'd0);
    check("rst_mispred", 64'(mispred), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_done", 64'(done), 64'd0);

    run_case("t1_taken", 2'd0, 16'h0001, 3, 1, 0, 0, 0, 0);
    check("t1_done_held", 64'(done), 64'd1);
    run_case("t2_loop", 2'd2, 16'h0001, 8, 1, 0, 0, 0, 0);
    run_case("t3_stall", 2'd1, 16'h0001, 4, 1, 0, 0, 5, 0);
    run_case("t4_lfsr", 2'd3, 16'h0000, 64, 0, 0, 0, 0, 0);
    run_case("t4_zero", 2'd0, 16'h0001, 0, 1, 0, 0, 0, 0);
    run_case("t5_abort", 2'd2, 16'h0005, 20, 1, 1, 0, 0, 3);
    run_case("t5_clean", 2'd0, 16'h0001, 4, 1, 0, 0, 0, 0);
    for (int r = 0; r < 10; r++) begin
      run_case("rnd", 2'($urandom), 16'($urandom), int'($urandom_range(20, 1)),
               int'($urandom_range(2, 0)), int'($urandom_range(1, 0)),
               int'($urandom_range(3, 0)), 0, 0);
    end

    // Narrow counters: fifteen branches all mispredicted
    @(posedge clk); #1;
    start4 = 1'b1; mode4 = 2'd0; seed4 = 16'h0001; num4 = 4'd15;
    @(posedge clk); #1;
    start4 = 1'b0;
    budget = 200;
    while (budget > 0 && !done4) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL t6_timeout: done4 %0d, expected 1", done4);
    end
    check("t6_issued", 64'(issued4), 64'hF);
    check("t6_mispred", 64'(mispred4), 64'hF);
    check("t6_busy", 64'(busy4), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
